// File: rtl/output_display.sv
// Output register of the 8-bit computer: latches a bus byte, converts it to decimal
// with an iterative double-dabble FSM and scans it onto a 4-digit 7-segment display.
module output_display #(
    parameter int unsigned REFRESH_BITS = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] bus,
    input  logic       OI,
    input  logic       load_stb,
    input  logic       signed_mode,
    output logic [7:0] value,
    output logic       busy,
    output logic [7:0] seg,
    output logic [3:0] sel
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned BCD_W  = 12;
    localparam int unsigned ITER_W = 4;
    localparam int unsigned STEP_W = BCD_W + DATA_W;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    state_t                  state_q, state_d;
    logic [DATA_W-1:0]       value_q;
    logic                    busy_q, busy_d;
    logic [ITER_W-1:0]       iter_q, iter_d;
    logic [DATA_W-1:0]       mag_q, mag_d;
    logic [BCD_W-1:0]        bcd_q, bcd_d;
    logic                    sign_q, sign_d;
    logic [3:0]              units_q, units_d;
    logic [3:0]              tens_q, tens_d;
    logic [3:0]              hund_q, hund_d;
    logic                    neg_q, neg_d;
    logic [REFRESH_BITS-1:0] cnt_q;
    logic [7:0]              seg_q, seg_d;
    logic [3:0]              sel_q, sel_d;

    logic                    load_c;
    logic [DATA_W-1:0]       mag_in_c;
    logic [STEP_W-1:0]       step_c;
    logic [1:0]              digit_idx_c;

    // One double-dabble iteration: add 3 to nibbles >= 5, then shift {bcd,mag} left.
    function automatic logic [STEP_W-1:0] dd_step(input logic [BCD_W-1:0] b,
                                                  input logic [DATA_W-1:0] m);
        logic [BCD_W-1:0] adj;
        adj = b;
        for (int i = 0; i < 3; i++) begin
            if (b[4*i +: 4] >= 4'd5) adj[4*i +: 4] = 4'(b[4*i +: 4] + 4'd3);
        end
        return STEP_W'({adj, m} << 1);
    endfunction

    function automatic logic [7:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 8'hC0;
            4'd1:    seg_code = 8'hF9;
            4'd2:    seg_code = 8'hA4;
            4'd3:    seg_code = 8'hB0;
            4'd4:    seg_code = 8'h99;
            4'd5:    seg_code = 8'h92;
            4'd6:    seg_code = 8'h82;
            4'd7:    seg_code = 8'hF8;
            4'd8:    seg_code = 8'h80;
            4'd9:    seg_code = 8'h90;
            default: seg_code = 8'hFF;
        endcase
    endfunction

    assign load_c   = OI & load_stb;
    assign mag_in_c = (signed_mode & value_q[7]) ? 8'(~value_q + 8'd1) : value_q;
    assign step_c   = dd_step(bcd_q, mag_q);

    // LOAD performs the first iteration so that eight iterations finish in N+1..N+8.
    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        mag_d   = mag_q;
        bcd_d   = bcd_q;
        sign_d  = sign_q;
        units_d = units_q;
        tens_d  = tens_q;
        hund_d  = hund_q;
        neg_d   = neg_q;
        case (state_q)
            LOAD: begin
                sign_d          = signed_mode & value_q[7];
                {bcd_d, mag_d}  = STEP_W'({12'd0, mag_in_c} << 1);
                iter_d          = 4'd1;
                state_d         = SHIFT;
            end
            SHIFT: begin
                {bcd_d, mag_d} = step_c;
                iter_d         = 4'(iter_q + 4'd1);
                if (iter_q == 4'd7) begin
                    units_d = step_c[11:8];
                    tens_d  = step_c[15:12];
                    hund_d  = step_c[19:16];
                    neg_d   = sign_q;
                    state_d = IDLE;
                end
            end
            default: ;
        endcase
        if (load_c) state_d = LOAD;
        busy_d = (state_d != IDLE);
    end

    // Digit selection for the next refresh frame; seg and sel are registered together.
    assign digit_idx_c = cnt_q[REFRESH_BITS-1 -: 2];

    always_comb begin
        seg_d = 8'hFF;
        sel_d = ~(4'b0001 << digit_idx_c);
        case (digit_idx_c)
            2'd0: seg_d = seg_code(units_q);
            2'd1: seg_d = (hund_q == 4'd0 && tens_q == 4'd0) ? 8'hFF : seg_code(tens_q);
            2'd2: seg_d = (hund_q == 4'd0) ? 8'hFF : seg_code(hund_q);
            2'd3: seg_d = neg_q ? 8'hBF : 8'hFF;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            value_q <= '0;
            busy_q  <= 1'b0;
            iter_q  <= '0;
            mag_q   <= '0;
            bcd_q   <= '0;
            sign_q  <= 1'b0;
            units_q <= '0;
            tens_q  <= '0;
            hund_q  <= '0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
            seg_q   <= 8'hC0;
            sel_q   <= 4'b1110;
        end else begin
            state_q <= state_d;
            if (load_c) value_q <= bus;
            busy_q  <= busy_d;
            iter_q  <= iter_d;
            mag_q   <= mag_d;
            bcd_q   <= bcd_d;
            sign_q  <= sign_d;
            units_q <= units_d;
            tens_q  <= tens_d;
            hund_q  <= hund_d;
            neg_q   <= neg_d;
            cnt_q   <= cnt_q + REFRESH_BITS'(1);
            seg_q   <= seg_d;
            sel_q   <= sel_d;
        end
    end

    assign value = value_q;
    assign busy  = busy_q;
    assign seg   = seg_q;
    assign sel   = sel_q;

endmodule

// File: tb/tb_output_display.sv
// Directed bench for output_display: scoreboard of expected bytes, decimal digit model,
// and per-digit readback of the scanned 7-segment outputs.
module tb_output_display;

    localparam int unsigned RB = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] bus;
    logic       OI;
    logic       load_stb;
    logic       signed_mode;
    logic [7:0] value;
    logic       busy;
    logic [7:0] seg;
    logic [3:0] sel;

    typedef struct {
        logic [7:0] val;
        logic       sm;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    output_display #(.REFRESH_BITS(RB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .OI         (OI),
        .load_stb   (load_stb),
        .signed_mode(signed_mode),
        .value      (value),
        .busy       (busy),
        .seg        (seg),
        .sel        (sel)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] seg_of(input int d);
        case (d)
            0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
            4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
            8: return 8'h80;  9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    // Expected segment code of digit k for a byte shown in the given mode.
    function automatic logic [7:0] exp_code(input logic [7:0] b, input logic sm, input int k);
        int  m;
        int  h, t, u;
        bit  neg;
        neg = sm && b[7];
        m   = neg ? (256 - int'(b)) : int'(b);
        h   = m / 100;
        t   = (m / 10) % 10;
        u   = m % 10;
        case (k)
            0: return seg_of(u);
            1: return (h == 0 && t == 0) ? 8'hFF : seg_of(t);
            2: return (h == 0) ? 8'hFF : seg_of(h);
            default: return neg ? 8'hBF : 8'hFF;
        endcase
    endfunction

    function automatic int ksel(input logic [3:0] s);
        case (s)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return -1;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_digit(input int k, output logic [7:0] s, output bit ok);
        logic [3:0] want;
        want = ~(4'b0001 << k);
        ok   = 1'b0;
        s    = 8'hFF;
        for (int c = 0; c < 64; c++) begin
            if (sel === want) begin
                ok = 1'b1;
                s  = seg;
                break;
            end
            tick();
        end
    endtask

    task automatic check_display(input string tag, input logic [7:0] b, input logic sm);
        logic [7:0] s;
        bit         ok;
        for (int k = 0; k < 4; k++) begin
            read_digit(k, s, ok);
            if (!ok) chk($sformatf("%s_d%0d_timeout", tag, k), 8'h00, 8'h01);
            else     chk($sformatf("%s_d%0d", tag, k), s, exp_code(b, sm, k));
        end
    endtask

    task automatic load_timed(input string tag, input logic [7:0] b, input logic sm);
        exp_t e;
        e.val = b;
        e.sm  = sm;
        sb.push_back(e);
        bus = b; signed_mode = sm; OI = 1'b1; load_stb = 1'b1;
        tick();
        OI = 1'b0; load_stb = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            chk($sformatf("%s_busy_n%0d", tag, c), 8'(busy), 8'h01);
            tick();
        end
        chk($sformatf("%s_busy_n9", tag), 8'(busy), 8'h00);
    endtask

    task automatic finish_conv(input string tag);
        exp_t e;
        bit   done;
        done = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (busy === 1'b0) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        if (!done) chk({tag, "_busy_timeout"}, 8'h00, 8'h01);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 8'h00, 8'h01);
        end else begin
            e = sb.pop_front();
            chk({tag, "_value"}, value, e.val);
            check_display(tag, e.val, e.sm);
        end
    endtask

    initial begin
        exp_t e;
        int   k;

        rst_n = 1'b0; bus = 8'h00; OI = 1'b0; load_stb = 1'b0; signed_mode = 1'b0;
        #12;
        chk("rst_value", value, 8'h00);
        chk("rst_busy", 8'(busy), 8'h00);
        chk("rst_seg", seg, 8'hC0);
        chk("rst_sel", 8'(sel), 8'h0E);
        rst_n = 1'b1;
        check_display("rst", 8'h00, 1'b0);

        load_timed("u2a", 8'h2A, 1'b0);  finish_conv("u2a");
        load_timed("uff", 8'hFF, 1'b0);  finish_conv("uff");
        load_timed("sff", 8'hFF, 1'b1);  finish_conv("sff");
        load_timed("s80", 8'h80, 1'b1);  finish_conv("s80");
        load_timed("s7f", 8'h7F, 1'b1);  finish_conv("s7f");

        // Restart: 2A at N, 05 at N+4; display holds "127" until the restarted commit.
        e.val = 8'h2A; e.sm = 1'b0; sb.push_back(e);
        bus = 8'h2A; signed_mode = 1'b0; OI = 1'b1; load_stb = 1'b1;
        tick();
        OI = 1'b0; load_stb = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (c == 5) begin
                OI = 1'b0; load_stb = 1'b0;
            end
            chk($sformatf("rs_busy_n%0d", c), 8'(busy), 8'h01);
            k = ksel(sel);
            if (k < 0) chk($sformatf("rs_sel_n%0d", c), 8'(sel), 8'h0E);
            else       chk($sformatf("rs_hold_n%0d", c), seg, exp_code(8'h7F, 1'b1, k));
            if (c == 4) begin
                bus = 8'h05; OI = 1'b1; load_stb = 1'b1;
                void'(sb.pop_back());
                e.val = 8'h05; e.sm = 1'b0; sb.push_back(e);
            end
            tick();
        end
        OI = 1'b0; load_stb = 1'b0;
        chk("rs_busy_n13", 8'(busy), 8'h00);
        finish_conv("rs05");

        // Strobe without OI and OI without strobe leave the register alone.
        bus = 8'hAA; OI = 1'b1; load_stb = 1'b0;
        repeat (3) tick();
        chk("oi_only_value", value, 8'h05);
        chk("oi_only_busy", 8'(busy), 8'h00);
        OI = 1'b0; load_stb = 1'b1;
        repeat (3) tick();
        load_stb = 1'b0;
        chk("stb_only_value", value, 8'h05);
        chk("stb_only_busy", 8'(busy), 8'h00);

        // Reset in the middle of a conversion discards it.
        bus = 8'h63; signed_mode = 1'b0; OI = 1'b1; load_stb = 1'b1;
        tick();
        OI = 1'b0; load_stb = 1'b0;
        repeat (4) tick();
        chk("mid_busy_pre", 8'(busy), 8'h01);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_value", value, 8'h00);
        chk("mid_rst_busy", 8'(busy), 8'h00);
        chk("mid_rst_seg", seg, 8'hC0);
        chk("mid_rst_sel", 8'(sel), 8'h0E);
        sb.delete();
        tick();
        rst_n = 1'b1;
        repeat (12) tick();
        chk("mid_post_busy", 8'(busy), 8'h00);
        check_display("mid_post", 8'h00, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
